inject_scheduler: RTL and testbench

INJECT_SCHEDULER -- requirements
Module: inject_scheduler

---
 rtl/noc_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/inject_scheduler.sv | 165 ++++++++++++++++
 tb/tb_inject_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, flit-type encodings, scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  // Default flit width; the two MSBs of every flit carry its type.
  localparam int FLIT_W = 20;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority encoder: first requester after last_grant, wrapping at NREQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is accepted.
//
// Ports:
//   req_vld    - request vector, one bit per source
//   last_grant - index of the previous winner (lowest priority this round)
//   winner     - winning index; equals last_grant when nothing requests
//   any_vld    - at least one request bit is set
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_vld,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_vld
);
  import noc_pkg::*;

  // Walk from the farthest candidate (last_grant itself) toward the nearest
  // (last_grant+1); the last hit is the highest-priority requester.
  always_comb begin
    winner  = last_grant;
    any_vld = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      if (req_vld[(int'(last_grant) + off) % NREQ]) begin
        winner  = IDX_W'((int'(last_grant) + off) % NREQ);
        any_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inject_scheduler.sv
// Local injection scheduler: round-robin across sources, packet-locked, credit-gated toward the router.
// Latency: 1 cycle from req_valid&req_ready to out_valid/dataout.
// Backpressure: req_ready drops when no router credit remains; credits return via single-cycle ci pulses.
//
// Ports:
//   clk, RST        - rising-edge clock, synchronous active-high reset
//   req_data        - NREQ flits, source i in [i*FLIT_W +: FLIT_W]
//   req_valid/ready - per-source handshake; at most one ready bit high
//   ci              - credit return pulse from the router local port
//   dataout         - registered flit toward the router (holds when out_valid low)
//   out_valid       - one-cycle pulse per accepted flit
//   credit_err      - sticky: credit returned while the counter was full
//   flit_count      - 16-bit wrapping count of injected flits
//                     (only when INJECT_SCHED_STATS_EN is defined)
module inject_scheduler #(
  parameter int NREQ      = 4,
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int BUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [NREQ*FLIT_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   ci,
  output logic [FLIT_W-1:0]      dataout,
  output logic                   out_valid,
  output logic                   credit_err
`ifdef INJECT_SCHED_STATS_EN
  ,
  output logic [15:0]            flit_count
`endif
);
  import noc_pkg::*;

  localparam int                IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int                CRED_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NREQ - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [CRED_W-1:0]   credit_q, credit_d;
  logic [FLIT_W-1:0]   dataout_q, dataout_d;
  logic                out_valid_q, out_valid_d;
  logic                credit_err_q, credit_err_d;

  logic [IDX_W-1:0]    rr_winner;
  logic                rr_any_vld;
  logic [IDX_W-1:0]    grant;
  logic [FLIT_W-1:0]   grant_flit;
  logic [1:0]          grant_type;
  logic                xfer;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_vld    (req_valid),
    .last_grant (last_grant_q),
    .winner     (rr_winner),
    .any_vld    (rr_any_vld)
  );

  // Grant / handshake. While locked, last_grant_q is the packet owner, so the
  // grant stays on it even when the owner idles.
  always_comb begin
    grant      = (state_q == ST_LOCKED) ? last_grant_q : rr_winner;
    grant_flit = req_data[int'(grant)*FLIT_W +: FLIT_W];
    grant_type = grant_flit[FLIT_W-1 -: 2];
    req_ready  = '0;
    // In IDLE with nobody asking there is nothing to accept, so stay quiet.
    if ((credit_q != '0) && !RST && ((state_q == ST_LOCKED) || rr_any_vld)) begin
      req_ready[grant] = 1'b1;
    end
    xfer = req_valid[grant] && req_ready[grant];
  end

  // Next state: packet lock, output register, credit accounting.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    dataout_d    = dataout_q;
    out_valid_d  = xfer;

    if (xfer) begin
      dataout_d = grant_flit;
      case (state_q)
        ST_IDLE: begin
          last_grant_d = grant;
          if (grant_type == FT_HEAD) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // A stray head inside a packet is forwarded and the lock is kept.
          if (grant_type == FT_TAIL) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A send and a return in the same cycle cancel out.
    case ({xfer, ci})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CRED_MAX) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_RST;
      credit_q     <= CRED_MAX;
      credit_err_q <= 1'b0;
      dataout_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      dataout_q    <= dataout_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign dataout    = dataout_q;
  assign out_valid  = out_valid_q;
  assign credit_err = credit_err_q;

`ifdef INJECT_SCHED_STATS_EN
  logic [15:0] flit_count_q, flit_count_d;

  // Natural 16-bit wrap from FFFF to 0.
  always_comb begin
    flit_count_d = flit_count_q;
    if (xfer) begin
      flit_count_d = flit_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      flit_count_q <= '0;
    end else begin
      flit_count_q <= flit_count_d;
    end
  end

  assign flit_count = flit_count_q;
`endif

endmodule

// File: tb/tb_inject_scheduler.sv
module tb_inject_scheduler;
  import noc_pkg::*;

  localparam int NREQ = 4;
  localparam int FW   = 20;
  localparam int BD   = 4;

  logic               clk = 1'b0;
  logic               RST = 1'b1;
  logic [NREQ*FW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic               ci = 1'b1;
  logic [FW-1:0]      dataout;
  logic               out_valid;
  logic               credit_err;
`ifdef INJECT_SCHED_STATS_EN
  logic [15:0]        flit_count;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [FW-1:0] sb_q[$];

  always #5 clk = ~clk;

  inject_scheduler #(
    .NREQ      (NREQ),
    .FLIT_W    (FW),
    .BUF_DEPTH (BD)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .ci         (ci),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .credit_err (credit_err)
`ifdef INJECT_SCHED_STATS_EN
    ,
    .flit_count (flit_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int p);
    return {t, 18'(p)};
  endfunction

  task automatic set_src(input int i, input logic v, input logic [FW-1:0] f);
    req_valid[i] = v;
    req_data[i*FW +: FW] = f;
  endtask

  // One cycle: check which source (if any) is accepted, queue its flit,
  // then after the edge check out_valid and pop/compare dataout.
  task automatic tick(input string tag, input int exp_src);
    logic [NREQ-1:0] exp_x;
    logic [FW-1:0]   exp_f;
    #1;
    exp_x = '0;
    if (exp_src >= 0) exp_x[exp_src] = 1'b1;
    check({tag, ".xfer"}, 32'(req_ready & req_valid), 32'(exp_x));
    if (exp_src >= 0) sb_q.push_back(req_data[exp_src*FW +: FW]);
    @(posedge clk);
    #1;
    check({tag, ".ovld"}, 32'(out_valid), 32'(exp_src >= 0));
    if (out_valid && sb_q.size() > 0) begin
      exp_f = sb_q.pop_front();
      check({tag, ".dout"}, 32'(dataout), 32'(exp_f));
    end
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    ci        = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    RST = 1'b0;
    ci  = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // Reset state, with ci held high to show it is ignored during reset.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.ovld",  32'(out_valid), 32'(0));
    check("rst.dout",  32'(dataout), 32'(0));
    check("rst.err",   32'(credit_err), 32'(0));
    check("rst.rdy",   32'(req_ready), 32'(0));
    check("rst.cred",  32'(dut.credit_q), 32'(BD));
    check("rst.state", 32'(dut.state_q), 32'(ST_IDLE));
    RST = 1'b0;
    ci  = 1'b0;

    // Round-robin fairness with credit returned every cycle.
    ci = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, mk(FT_SINGLE, r*16 + i));
      tick($sformatf("rr%0d", r), r % NREQ);
    end
    check("rr.cred", 32'(dut.credit_q), 32'(BD));
    check("rr.err",  32'(credit_err), 32'(0));

    // Packet lock: source 1 owns the port until its tail; source 2 waits.
    do_reset();
    ci = 1'b1;
    set_src(2, 1'b1, mk(FT_SINGLE, 'h200));
    set_src(1, 1'b1, mk(FT_HEAD, 'h101));
    tick("lk.head", 1);
    check("lk.state", 32'(dut.state_q), 32'(ST_LOCKED));
    set_src(1, 1'b1, mk(FT_BODY, 'h102));
    tick("lk.body1", 1);
    set_src(1, 1'b0, mk(FT_BODY, 'h1FF));
    tick("lk.gap", -1);
    set_src(1, 1'b1, mk(FT_BODY, 'h103));
    tick("lk.body2", 1);
    set_src(1, 1'b1, mk(FT_HEAD, 'h104));
    tick("lk.headin", 1);
    check("lk.state2", 32'(dut.state_q), 32'(ST_LOCKED));
    set_src(1, 1'b1, mk(FT_TAIL, 'h105));
    tick("lk.tail", 1);
    set_src(1, 1'b0, mk(FT_SINGLE, 0));
    tick("lk.src2", 2);
    set_src(2, 1'b0, mk(FT_SINGLE, 0));

    // Credit exhaustion: 4 credits, no returns.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_src(0, 1'b1, mk(FT_SINGLE, 'h300 + k));
      tick($sformatf("ex%0d", k), (k < BD) ? 0 : -1);
    end
    check("ex.cred0", 32'(dut.credit_q), 32'(0));
    check("ex.rdy0",  32'(req_ready[0]), 32'(0));
    ci = 1'b1;
    tick("ex.ci", -1);
    ci = 1'b0;
    set_src(0, 1'b1, mk(FT_SINGLE, 'h310));
    tick("ex.one", 0);
    tick("ex.after", -1);
    set_src(0, 1'b0, mk(FT_SINGLE, 0));
    ci = 1'b1;
    for (int k = 0; k < BD; k++) tick("ex.refill", -1);
    ci = 1'b0;
    check("ex.cred4", 32'(dut.credit_q), 32'(BD));
    check("ex.err",   32'(credit_err), 32'(0));

    // Simultaneous send+return at credit 2, then an overflow return.
    set_src(0, 1'b1, mk(FT_SINGLE, 'h400));
    tick("sc.a", 0);
    set_src(0, 1'b1, mk(FT_SINGLE, 'h401));
    tick("sc.b", 0);
    check("sc.cred2", 32'(dut.credit_q), 32'(2));
    ci = 1'b1;
    set_src(0, 1'b1, mk(FT_SINGLE, 'h402));
    tick("sc.both", 0);
    check("sc.hold2", 32'(dut.credit_q), 32'(2));
    set_src(0, 1'b0, mk(FT_SINGLE, 0));
    tick("sc.ret1", -1);
    tick("sc.ret2", -1);
    check("sc.err0", 32'(credit_err), 32'(0));
    tick("sc.over", -1);
    ci = 1'b0;
    check("sc.err1",  32'(credit_err), 32'(1));
    check("sc.cred4", 32'(dut.credit_q), 32'(BD));
    tick("sc.sticky", -1);
    check("sc.err1b", 32'(credit_err), 32'(1));

    // Reset in the middle of source 3's packet.
    set_src(3, 1'b1, mk(FT_HEAD, 'h500));
    tick("mr.head", 3);
    check("mr.lock", 32'(dut.state_q), 32'(ST_LOCKED));
    RST = 1'b1;
    ci  = 1'b1;
    set_src(0, 1'b1, mk(FT_SINGLE, 'h0AA));
    set_src(3, 1'b1, mk(FT_BODY, 'h501));
    tick("mr.rst", -1);
    check("mr.state", 32'(dut.state_q), 32'(ST_IDLE));
    check("mr.cred",  32'(dut.credit_q), 32'(BD));
    check("mr.err",   32'(credit_err), 32'(0));
    check("mr.dout",  32'(dataout), 32'(0));
    RST = 1'b0;
    ci  = 1'b0;
    tick("mr.src0", 0);
    req_valid = '0;

`ifdef INJECT_SCHED_STATS_EN
    do_reset();
    check("st.zero", 32'(flit_count), 32'(0));
    ci = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_src(0, 1'b1, mk(FT_SINGLE, 'h600 + k));
      tick("st.x", 0);
    end
    check("st.ten", 32'(flit_count), 32'(10));
    // One flit per cycle keeps flowing while we count up to the wrap.
    for (int k = 0; k < 65525; k++) @(posedge clk);
    #1;
    check("st.ffff", 32'(flit_count), 32'('hFFFF));
    @(posedge clk);
    #1;
    check("st.wrap", 32'(flit_count), 32'(0));
    req_valid = '0;
    ci = 1'b0;
`endif

    check("sb.empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
